// File: rtl/_demux2_buf_fifo2.sv
// Two-entry FIFO used as one output buffer of the demux. The head is always held
// in slot 0, so the consumer sees a registered word with no read mux.
module _fifo2 #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [n-1:0] push_data,
    input  logic         pop,
    output logic [n-1:0] head_data,
    output logic [1:0]   count
);

    logic [n-1:0] mem0, mem1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) mem0 <= push_data;
                    else               mem1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    mem1  <= '0;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Old head leaves; the new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        mem0 <= push_data;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = mem0;

endmodule

// File: rtl/_demux2_buf.sv
// Buffered 1-to-2 stream demux: each producer word is steered by in_sel into one
// of two 2-entry FIFOs, each drained by its own valid/ready consumer.
module _demux2_buf #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sel,
    input  logic [n-1:0] in_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [n-1:0] out0_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic [n-1:0] out1_data,
    output logic [1:0]   out0_count,
    output logic [1:0]   out1_count
);

    logic push0, push1, pop0, pop1, acc;

    // in_ready looks only at registered counts, never at the consumer readies.
    assign in_ready = in_sel ? (out1_count != 2'd2) : (out0_count != 2'd2);
    assign acc      = in_valid & in_ready;
    assign push0    = acc & ~in_sel;
    assign push1    = acc &  in_sel;
    assign pop0     = out0_valid & out0_ready;
    assign pop1     = out1_valid & out1_ready;

    assign out0_valid = (out0_count != 2'd0);
    assign out1_valid = (out1_count != 2'd0);

    _fifo2 #(.n(n)) u_buf0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push0),
        .push_data (in_data),
        .pop       (pop0),
        .head_data (out0_data),
        .count     (out0_count)
    );

    _fifo2 #(.n(n)) u_buf1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push1),
        .push_data (in_data),
        .pop       (pop1),
        .head_data (out1_data),
        .count     (out1_count)
    );

    // A stalled head must stay put until it is popped or flushed.
    a_out0_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out0_valid && !out0_ready && !flush) |=> (out0_valid && $stable(out0_data)));
    a_out1_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out1_valid && !out1_ready && !flush) |=> (out1_valid && $stable(out1_data)));

endmodule

// File: tb/tb__demux2_buf.sv
// Bench for _demux2_buf: a queue model per output checked every cycle, a table of
// directed cycles, and hand-written random, flush and reset sequences.
module tb__demux2_buf;

    logic        clk, rst_n, flush, in_valid, in_ready, in_sel;
    logic [31:0] in_data, out0_data, out1_data;
    logic        out0_valid, out0_ready, out1_valid, out1_ready;
    logic [1:0]  out0_count, out1_count;

    int nvec = 0;
    int nmis = 0;
    int nacc = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    _demux2_buf #(.n(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out0_count (out0_count),
        .out1_count (out1_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: compare DUT against the queue model, then advance the model.
    always @(negedge clk) begin
        logic er;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            er = (in_sel ? q1.size() : q0.size()) < 2;
            chk("in_ready", {31'd0, in_ready}, {31'd0, er});
            chk("out0_count", {30'd0, out0_count}, 32'(q0.size()));
            chk("out1_count", {30'd0, out1_count}, 32'(q1.size()));
            chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
            chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
            if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
            if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
            if (flush) begin
                q0.delete();
                q1.delete();
            end else begin
                if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
                if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
                if (in_valid && er) begin
                    if (in_sel) q1.push_back(in_data);
                    else        q0.push_back(in_data);
                    nacc++;
                end
            end
        end
    end

    typedef struct {
        logic        v;
        logic        s;
        logic [31:0] d;
        logic        r0;
        logic        r1;
        logic        er;
        logic [1:0]  e0;
        logic [1:0]  e1;
    } vec_t;

    vec_t tbl[$];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valids", {30'd0, out0_valid, out1_valid}, 32'd0);
        chk("rst_counts", {28'd0, out0_count, out1_count}, 32'd0);
        chk("rst_data0", out0_data, 32'd0);
        chk("rst_data1", out1_data, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // routing
        tbl.push_back('{1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0});
        tbl.push_back('{1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd0, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd0, 2'd0});
        // backpressure and cross-path independence
        tbl.push_back('{1'b1, 1'b0, 32'h1,        1'b0, 1'b1, 1'b1, 2'd0, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 32'h2,        1'b0, 1'b1, 1'b1, 2'd1, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 32'h3,        1'b0, 1'b1, 1'b0, 2'd2, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 32'h3,        1'b0, 1'b1, 1'b0, 2'd2, 2'd0});
        tbl.push_back('{1'b1, 1'b1, 32'hBEEF,     1'b0, 1'b0, 1'b1, 2'd2, 2'd0});
        tbl.push_back('{1'b1, 1'b0, 32'h3,        1'b1, 1'b0, 1'b0, 2'd2, 2'd1});
        tbl.push_back('{1'b1, 1'b0, 32'h3,        1'b1, 1'b1, 1'b1, 2'd1, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd1, 2'd0});
        tbl.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd0, 2'd0});
        // simultaneous push and pop on out1
        tbl.push_back('{1'b1, 1'b1, 32'h44,       1'b1, 1'b0, 1'b1, 2'd0, 2'd0});
        tbl.push_back('{1'b1, 1'b1, 32'h55,       1'b1, 1'b1, 1'b1, 2'd0, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 2'd0, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd0, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd0, 2'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            in_valid = tbl[i].v; in_sel = tbl[i].s; in_data = tbl[i].d;
            out0_ready = tbl[i].r0; out1_ready = tbl[i].r1;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].er});
            chk($sformatf("tbl%0d_c0", i), {30'd0, out0_count}, {30'd0, tbl[i].e0});
            chk($sformatf("tbl%0d_c1", i), {30'd0, out1_count}, {30'd0, tbl[i].e1});
            step();
        end

        // sustained stream, both consumers always ready
        a = nacc;
        in_valid = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_sel = 1'($urandom_range(0, 1));
            in_data = $urandom;
            step();
        end
        in_valid = 1'b0;
        chk("throughput", 32'(nacc - a), 32'd100);
        for (int i = 0; i < 10 && (q0.size() + q1.size()) != 0; i++) step();
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);

        // flush with both buffers full
        out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
        in_sel = 1'b0; in_data = 32'h11; step();
        in_sel = 1'b1; in_data = 32'h21; step();
        in_sel = 1'b0; in_data = 32'h12; step();
        in_sel = 1'b1; in_data = 32'h22; step();
        flush = 1'b1; in_sel = 1'b0; in_data = 32'h99; step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_counts", {28'd0, out0_count, out1_count}, 32'd0);
        chk("flush_valids", {30'd0, out0_valid, out1_valid}, 32'd0);
        step();

        // flush drops a push that would otherwise have been accepted
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h7; step();
        flush = 1'b1; in_data = 32'h8; step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_drop_c0", {30'd0, out0_count}, 32'd0);
        chk("flush_drop_v0", {31'd0, out0_valid}, 32'd0);
        step();

        // reset pulsed mid-stream
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_sel = i[0]; in_data = 32'hC0 + 32'(i); step();
        end
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_valids", {30'd0, out0_valid, out1_valid}, 32'd0);
        chk("mrst_counts", {28'd0, out0_count, out1_count}, 32'd0);
        chk("mrst_data", out0_data | out1_data, 32'd0);
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/_demux2_buf.md
Name: _demux2_buf

Overview:
- Buffered 1-to-2 stream demultiplexer. It is the inverse of the 2-input word mux: one producer stream is steered to one of two consumer streams.
- Each word is routed by a per-word select bit into a 2-entry output buffer. Every interface uses a valid/ready handshake.
- Used in the CPU datapath wherever a single result or writeback stream must be split between two consumers, e.g. register-file writeback vs. memory store path.

Parameters:
n  WORD_LENGTH  width of data words in bits
DEPTH  2  entries per output buffer; fixed at 2, and other values are not supported

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of both buffers
in_valid  input  1  producer word valid
in_ready  output  1  block can accept a word for the selected output
in_sel  input  1  destination of the current word: 0 = out0, 1 = out1
in_data  input  n  producer word
out0_valid  output  1  out0 head entry valid
out0_ready  input  1  consumer 0 accepts
out0_data  output  n  out0 head entry
out1_valid  output  1  out1 head entry valid
out1_ready  input  1  consumer 1 accepts
out1_data  output  n  out1 head entry
out0_count  output  2  occupancy of buffer 0 (0..2)
out1_count  output  2  occupancy of buffer 1 (0..2)

Behaviour:
- Reset:
  - rst_n low asynchronously clears both buffers: counts 0, outX_valid 0, outX_data 0, in_ready 1.
  - Reset asserted mid-transfer discards all buffered words with no partial state.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready at a rising edge. Output transfer occurs when outX_valid & outX_ready.
  - in_ready = (count of buffer selected by in_sel) < 2. It depends only on registered state and in_sel; there is no combinational path from out0_ready/out1_ready to in_ready.
  - A word accepted at edge N is visible on the selected outX_data with outX_valid high after edge N, so latency is 1 cycle.
- Buffer structure:
  - Each buffer is a 2-entry FIFO with head at outX_data and outX_valid = (count != 0).
  - outX_data is stable while outX_valid is high and outX_ready is low.
- Count updates, per buffer, per edge:
  - push only: count + 1
  - pop only: count - 1
  - push and pop together: count unchanged, old head leaves, pushed word enters behind the remaining entry. With count 1 the pushed word becomes the new head.
  - push when count is 2 cannot occur, because in_ready is low.
- Throughput: one word per cycle sustained to either output, provided the consumer is ready every cycle.
- Independence:
  - A full buffer on one side does not block words destined for the other side. in_ready re-evaluates as in_sel changes.
  - Ordering is preserved per output only. There is no ordering guarantee across outputs.
- Simultaneous events:
  - Pops on both outputs and a push in the same cycle are all honoured.
  - flush has priority over push and pop in that cycle: both counts go to 0, and any push in that cycle is dropped. in_ready still reflects pre-flush state and the producer must not rely on it during flush.
- Producer rule: in_data and in_sel must be held while in_valid is high and in_ready is low. The block does not check this.
- Protocol checks: outX_valid must not drop without a pop or flush; simulation assertions cover this.

Decomposition:
- WORD_LENGTH comes from the shared constants.vh; add no new package.
- One sub-module is natural: _fifo2 (parameter n; clk, rst_n, flush, push, push_data, pop, head_data, count). Instantiate it twice.
- The top level then holds only the select steering, in_ready generation and the valid/count outputs.

Test Plan:
- Reset: assert rst_n=0 with stale state -> in_ready=1, out0_valid=out1_valid=0, both counts 0, outX_data=0, immediately and asynchronously.
- Routing: push 0xA5A5A5A5 with sel 0, then 0x12345678 with sel 1, both consumers ready -> 0xA5A5A5A5 on out0 one cycle after its accept, 0x12345678 on out1 one cycle after its accept.
- Backpressure: out0_ready=0, push 0x1, 0x2, 0x3 to out0 -> third word stalls (in_ready=0, out0_count=2); raise out0_ready -> out0 emits 1, 2, 3 in order, and word 3 is accepted the cycle after the first pop.
- Cross-path independence: out0 full with out0_ready=0, present sel 1 with 0xBEEF -> in_ready=1, accepted, appears on out1 while out0 holds 0x1.
- Simultaneous push and pop: out1_count=1 and out1_ready=1, push 0x55 to out1 -> count stays 1 and 0x55 becomes the head the next cycle; a 100-word random stream with both consumers always ready sustains 1 word per cycle.
- Flush: both buffers at count 2, assert flush with in_valid=1 -> next cycle both counts 0, outputs invalid, pushed word absent. Repeat with rst_n pulsed mid-stream -> same empty state.
